// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

   localparam int DATA_W_DEFAULT   = 32;
   localparam int NUM_REGS_DEFAULT = 16;
   localparam int NUM_RD_DEFAULT   = 2;
   localparam int REG_ZERO         = 0;

   function automatic int addr_width(input int num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-stage bus of the register file: read ports, writeback and issue reservation.
interface regfile_sb_if #(
   parameter int DATA_W   = regfile_pkg::DATA_W_DEFAULT,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS_DEFAULT,
   parameter int NUM_RD   = regfile_pkg::NUM_RD_DEFAULT
);
   import regfile_pkg::*;

   localparam int ADDR_W = addr_width(NUM_REGS);

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic                     any_busy;
   logic                     waw_err;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_busy, any_busy, waw_err
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_busy, any_busy, waw_err
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy bits set at issue, cleared at writeback, sticky WAW error.
// REGFILE_BYPASS_EN makes a same-cycle writeback hide the busy flag of the register it releases.
module regfile_scoreboard #(
   parameter int NUM_REGS = regfile_pkg::NUM_REGS_DEFAULT,
   parameter int NUM_RD   = regfile_pkg::NUM_RD_DEFAULT,
   parameter int ADDR_W   = regfile_pkg::addr_width(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic                     any_busy,
   output logic                     waw_err
);
   import regfile_pkg::*;

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                waw_err_q, waw_err_d;
   logic                wr_hit, rsv_hit;

   // Release before reserve so a same-edge issue to the written register leaves it busy.
   always_comb begin
      busy_d    = busy_q;
      waw_err_d = waw_err_q;
      wr_hit    = wr_en  && (wr_addr  != ADDR_W'(REG_ZERO));
      rsv_hit   = rsv_en && (rsv_addr != ADDR_W'(REG_ZERO));
      if (wr_hit) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (rsv_hit) begin
         if (busy_q[rsv_addr] && !(wr_hit && (wr_addr == rsv_addr))) begin
            waw_err_d = 1'b1;
         end
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= '0;
         waw_err_q <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         waw_err_q <= waw_err_d;
      end
   end

   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_busy[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
         if (wr_hit && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
            rd_busy[i] = 1'b0;
         end
`endif
      end
   end

   assign any_busy = |rd_busy;
   assign waw_err  = waw_err_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard; register 0 reads as zero.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb #(
   parameter int DATA_W   = regfile_pkg::DATA_W_DEFAULT,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS_DEFAULT,
   parameter int NUM_RD   = regfile_pkg::NUM_RD_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_sb_if.slave  bus
);
   import regfile_pkg::*;

   localparam int ADDR_W = addr_width(NUM_REGS);

   logic [DATA_W-1:0]        regs_q [NUM_REGS];
   logic [DATA_W-1:0]        regs_d [NUM_REGS];
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic                     wr_hit;

   always_comb begin
      regs_d = regs_q;
      wr_hit = bus.wr_en && (bus.wr_addr != ADDR_W'(REG_ZERO));
      if (wr_hit) begin
         regs_d[bus.wr_addr] = bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Write-first forwarding overrides the stored value when enabled.
   always_comb begin
      rd_data_c = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (bus.rd_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO)) begin
            rd_data_c[i*DATA_W +: DATA_W] = regs_q[bus.rd_addr[i*ADDR_W +: ADDR_W]];
         end
`ifdef REGFILE_BYPASS_EN
         if (wr_hit && (bus.wr_addr == bus.rd_addr[i*ADDR_W +: ADDR_W])) begin
            rd_data_c[i*DATA_W +: DATA_W] = bus.wr_data;
         end
`endif
      end
   end

   assign bus.rd_data = rd_data_c;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .rsv_en   (bus.rsv_en),
      .rsv_addr (bus.rsv_addr),
      .rd_addr  (bus.rd_addr),
      .rd_busy  (bus.rd_busy),
      .any_busy (bus.any_busy),
      .waw_err  (bus.waw_err)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: table vectors, hand-written corner sequences and random traffic vs. a reference model.
module tb_regfile_sb;

   localparam int DW  = 32;
   localparam int NR  = 16;
   localparam int NRD = 2;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

   regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic [31:0] mMem  [NR];
   bit          mBusy [NR];
   bit          mWaw;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      bit          we;
      logic [3:0]  wa;
      logic [31:0] wd;
      bit          re;
      logic [3:0]  ra;
      logic [3:0]  r0;
      logic [3:0]  r1;
      logic [31:0] d0;
      logic [31:0] d1;
      bit          b0;
      bit          b1;
      bit          waw;
   } vec_t;

   vec_t vecs [13];

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic modelClear();
      for (int r = 0; r < NR; r++) begin
         mMem[r]  = '0;
         mBusy[r] = 1'b0;
      end
      mWaw = 1'b0;
   endtask

   // Architectural effect of one rising edge, taken straight from the register file's rules.
   task automatic modelEdge();
      int  wa = int'(bus.wr_addr);
      int  ra = int'(bus.rsv_addr);
      bit  wrOk  = bus.wr_en  && (wa != 0);
      bit  rsvOk = bus.rsv_en && (ra != 0);
      if (rsvOk && mBusy[ra] && !(wrOk && (wa == ra))) mWaw = 1'b1;
      if (wrOk) begin
         mMem[wa]  = bus.wr_data;
         mBusy[wa] = 1'b0;
      end
      if (rsvOk) mBusy[ra] = 1'b1;
   endtask

   function automatic logic [31:0] expData(input int a);
      if (a == 0) return '0;
      if (BYP && bus.wr_en && (int'(bus.wr_addr) == a)) return bus.wr_data;
      return mMem[a];
   endfunction

   function automatic bit expBusy(input int a);
      if (a == 0) return 1'b0;
      if (BYP && bus.wr_en && (int'(bus.wr_addr) == a)) return 1'b0;
      return mBusy[a];
   endfunction

   task automatic applyStimulus(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                                input bit re, input logic [3:0] ra,
                                input logic [3:0] r0, input logic [3:0] r1);
      bus.wr_en    = we;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
      bus.rsv_en   = re;
      bus.rsv_addr = ra;
      bus.rd_addr  = {r1, r0};
   endtask

   task automatic checkOutput(input string tag);
      int a0 = int'(bus.rd_addr[3:0]);
      int a1 = int'(bus.rd_addr[7:4]);
      bit e0 = expBusy(a0);
      bit e1 = expBusy(a1);
      checkVal({tag, " rd_data0"}, bus.rd_data[31:0],  expData(a0));
      checkVal({tag, " rd_data1"}, bus.rd_data[63:32], expData(a1));
      checkVal({tag, " rd_busy0"}, 32'(bus.rd_busy[0]), 32'(e0));
      checkVal({tag, " rd_busy1"}, 32'(bus.rd_busy[1]), 32'(e1));
      checkVal({tag, " any_busy"}, 32'(bus.any_busy), 32'(e0 | e1));
      checkVal({tag, " waw_err"},  32'(bus.waw_err), 32'(mWaw));
   endtask

   task automatic stepClock();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
      modelClear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);

      vecs[0]  = '{1'b1, 4'd7, 32'hBEFF556A, 1'b0, 4'd0, 4'd1, 4'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 4'd0, 32'h00001234, 1'b0, 4'd0, 4'd7, 4'd0, 32'hBEFF556A, 32'h0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd0, 4'd7, 32'h0, 32'hBEFF556A, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 4'd3, 32'h0000005A, 1'b0, 4'd0, 4'd7, 4'd1, 32'hBEFF556A, 32'h0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd3, 32'h5A, 32'h5A, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd3, 32'h0, 32'h5A, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 4'd4, 32'h00000077, 1'b0, 4'd0, 4'd0, 4'd7, 32'h0, 32'hBEFF556A, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 4'd4, 32'h00000099, 1'b1, 4'd4, 4'd7, 4'd0, 32'hBEFF556A, 32'h0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd7, 32'h99, 32'hBEFF556A, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd0, 4'd4, 32'h0, 32'h99, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd4, 32'h0, 32'h99, 1'b0, 1'b1, 1'b1};

      @(negedge clk);
      doReset();

      for (int a = 0; a < NR; a++) begin
         applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'(a), 4'(NR - 1 - a));
         #1;
         checkVal("reset rd_data0", bus.rd_data[31:0], 32'h0);
         checkVal("reset rd_data1", bus.rd_data[63:32], 32'h0);
         checkVal("reset rd_busy", 32'(bus.rd_busy), 32'h0);
         checkVal("reset any_busy", 32'(bus.any_busy), 32'h0);
         checkVal("reset waw_err", 32'(bus.waw_err), 32'h0);
         stepClock();
      end

      for (int v = 0; v < 13; v++) begin
         applyStimulus(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re, vecs[v].ra, vecs[v].r0, vecs[v].r1);
         #1;
         checkVal($sformatf("vec%0d rd_data0", v), bus.rd_data[31:0],  vecs[v].d0);
         checkVal($sformatf("vec%0d rd_data1", v), bus.rd_data[63:32], vecs[v].d1);
         checkVal($sformatf("vec%0d rd_busy0", v), 32'(bus.rd_busy[0]), 32'(vecs[v].b0));
         checkVal($sformatf("vec%0d rd_busy1", v), 32'(bus.rd_busy[1]), 32'(vecs[v].b1));
         checkVal($sformatf("vec%0d any_busy", v), 32'(bus.any_busy), 32'(vecs[v].b0 | vecs[v].b1));
         checkVal($sformatf("vec%0d waw_err", v),  32'(bus.waw_err), 32'(vecs[v].waw));
         stepClock();
      end

      // Forwarding: same-cycle visibility only when bypass is built in.
      applyStimulus(1'b1, 4'd5, 32'hA0, 1'b0, 4'd0, 4'd5, 4'd5);
      #1;
      checkVal("byp wr r5 data", bus.rd_data[31:0], BYP ? 32'hA0 : 32'h0);
      checkVal("byp wr r5 busy", 32'(bus.rd_busy[0]), 32'h0);
      stepClock();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd5, 4'd0);
      #1;
      checkVal("byp next data", bus.rd_data[31:0], 32'hA0);
      stepClock();
      applyStimulus(1'b1, 4'd5, 32'hB1, 1'b0, 4'd0, 4'd5, 4'd0);
      #1;
      checkVal("byp release data", bus.rd_data[31:0], BYP ? 32'hB1 : 32'hA0);
      checkVal("byp release busy", 32'(bus.rd_busy[0]), BYP ? 32'h0 : 32'h1);
      checkVal("byp release any", 32'(bus.any_busy), BYP ? 32'h0 : 32'h1);
      stepClock();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd0);
      #1;
      checkVal("byp after data", bus.rd_data[31:0], 32'hB1);
      checkVal("byp after busy", 32'(bus.rd_busy[0]), 32'h0);
      stepClock();

      // Same-edge reserve and writeback on a busy register: no WAW error, busy stays set.
      doReset();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd0, 4'd0);
      stepClock();
      applyStimulus(1'b1, 4'd4, 32'h99, 1'b1, 4'd4, 4'd0, 4'd0);
      stepClock();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd0);
      #1;
      checkVal("same-edge data", bus.rd_data[31:0], 32'h99);
      checkVal("same-edge busy", 32'(bus.rd_busy[0]), 32'h1);
      checkVal("same-edge waw", 32'(bus.waw_err), 32'h0);
      stepClock();

      for (int n = 0; n < 400; n++) begin
         logic [3:0] wa = 4'($urandom_range(0, NR - 1));
         logic [3:0] r0 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, NR - 1));
         applyStimulus(1'($urandom_range(0, 1)), wa, $urandom(),
                       ($urandom_range(0, 2) == 0), 4'($urandom_range(0, NR - 1)),
                       r0, 4'($urandom_range(0, NR - 1)));
         #1;
         checkOutput($sformatf("rand%0d", n));
         stepClock();
      end

      // Asynchronous reset between edges with a write pending.
      applyStimulus(1'b1, 4'd7, 32'hBEFF556A, 1'b0, 4'd0, 4'd0, 4'd0);
      stepClock();
      applyStimulus(1'b1, 4'd9, 32'hDEAD, 1'b1, 4'd9, 4'd7, 4'd9);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("async rd_data0", bus.rd_data[31:0], 32'h0);
      checkVal("async rd_data1", bus.rd_data[63:32], 32'h0);
      checkVal("async rd_busy", 32'(bus.rd_busy), 32'h0);
      checkVal("async waw_err", 32'(bus.waw_err), 32'h0);
      modelClear();
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd9, 4'd7);
      #1;
      rst_n = 1'b1;
      stepClock();
      #1;
      checkVal("async discard r9", bus.rd_data[31:0], 32'h0);
      checkVal("async cleared r7", bus.rd_data[63:32], 32'h0);
      checkVal("async busy r9", 32'(bus.rd_busy[0]), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
